// File: rtl/cp0_pkg.sv
// Shared constants and types for the coprocessor-0 interrupt controller.
package cp0_pkg;

   localparam logic [2:0] SEL_EPC     = 3'd0;
   localparam logic [2:0] SEL_STATUS  = 3'd1;
   localparam logic [2:0] SEL_MASK    = 3'd2;
   localparam logic [2:0] SEL_CAUSE   = 3'd3;
   localparam logic [2:0] SEL_COUNT   = 3'd4;
   localparam logic [2:0] SEL_COMPARE = 3'd5;

   localparam int unsigned ST_IE  = 0;
   localparam int unsigned ST_EXL = 1;

   localparam logic [5:0] ERET_FUNCT = 6'b011000;

   typedef enum logic {
      IDLE    = 1'b0,
      HANDLER = 1'b1
   } state_e;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module prio_enc #(
   parameter int unsigned W = 8,
   localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int unsigned i = W; i > 0; i--) begin
         if (req[i-1]) idx = IW'(i - 1);
      end
   end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor-0 exception/interrupt controller: edge-captured sticky sources,
// mask + fixed priority, EPC/Status/Mask/Cause, ERET return.
// Optional Count/Compare timer source enabled by defining CP0_TIMER_EN.
module cp0_intc
   import cp0_pkg::*;
#(
   parameter int unsigned          NUM_SRC  = 8,
   parameter int unsigned          DATA_W   = 32,
   parameter logic [DATA_W-1:0]    VEC_ADDR = 32'h0000_0004
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        inst,
   input  logic               cp0_en,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [DATA_W-1:0]  pc_in,
   input  logic [DATA_W-1:0]  din,
   output logic [DATA_W-1:0]  dout,
   output logic               reg_write,
   output logic               is_eret,
   output logic               exc_take,
   output logic [DATA_W-1:0]  vec_pc,
   output logic [DATA_W-1:0]  epc_out,
   output logic               in_handler
);

`ifdef CP0_TIMER_EN
   localparam int unsigned NT = NUM_SRC + 1;
`else
   localparam int unsigned NT = NUM_SRC;
`endif
   localparam int unsigned IW = (NT > 1) ? $clog2(NT) : 1;

   state_e               state_q, state_d;
   logic [DATA_W-1:0]    epc_q, epc_d;
   logic                 ie_q, ie_d;
   logic                 exl_q, exl_d;
   logic [NT-1:0]        mask_q, mask_d;
   logic [7:0]           code_q, code_d;
   logic [NT-1:0]        pend_q, pend_d;
   logic [NUM_SRC-1:0]   src_q, src_d;
`ifdef CP0_TIMER_EN
   logic [DATA_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]    cmp_q, cmp_d;
`endif

   logic [2:0]    sel;
   logic          mtc0;
   logic          win_valid;
   logic [IW-1:0] win_idx;
   logic          unused_inst;

   assign unused_inst = ^{inst[31:24], inst[22:14], inst[10:6]};

   prio_enc #(.W(NT)) u_prio (
      .req   (pend_q & mask_q),
      .valid (win_valid),
      .idx   (win_idx)
   );

   // Instruction decode and the combinational take decision.
   always_comb begin
      sel        = inst[13:11];
      mtc0       = cp0_en & inst[23];
      is_eret    = cp0_en & (inst[5:0] == ERET_FUNCT);
      reg_write  = cp0_en & ~inst[23] & ~is_eret;
      exc_take   = (state_q == IDLE) & ie_q & win_valid;
      vec_pc     = VEC_ADDR;
      epc_out    = epc_q;
      in_handler = (state_q == HANDLER);
   end

   // Next-state logic: pending capture, FSM, and MTC0 writes.
   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      ie_d    = ie_q;
      exl_d   = exl_q;
      mask_d  = mask_q;
      code_d  = code_q;
      src_d   = irq_src;
      pend_d  = pend_q;
`ifdef CP0_TIMER_EN
      count_d = count_q + 1'b1;
      cmp_d   = cmp_q;
      if (mtc0 && sel == SEL_COUNT)   count_d = din;
      if (mtc0 && sel == SEL_COMPARE) begin
         cmp_d          = din;
         pend_d[NT-1]   = 1'b0;
      end
`endif
      // Clears are applied before sets so a coincident new edge survives.
      if (exc_take) pend_d[win_idx] = 1'b0;
      pend_d[NUM_SRC-1:0] = pend_d[NUM_SRC-1:0] | (irq_src & ~src_q);
`ifdef CP0_TIMER_EN
      if (count_q == cmp_q) pend_d[NT-1] = 1'b1;
`endif

      case (state_q)
         IDLE: begin
            if (exc_take) begin
               state_d = HANDLER;
               epc_d   = pc_in;
               code_d  = 8'(win_idx) + 8'd1;
               exl_d   = 1'b1;
            end
         end
         HANDLER: begin
            if (is_eret) begin
               state_d = IDLE;
               exl_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (mtc0 && !exc_take) begin
         if (sel == SEL_EPC)    epc_d = din;
         if (sel == SEL_STATUS) ie_d  = din[ST_IE];
      end
      if (mtc0 && sel == SEL_MASK) mask_d = din[NT-1:0];
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         epc_q   <= '0;
         ie_q    <= 1'b0;
         exl_q   <= 1'b0;
         mask_q  <= '0;
         code_q  <= '0;
         pend_q  <= '0;
         src_q   <= '0;
`ifdef CP0_TIMER_EN
         count_q <= '0;
         cmp_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         ie_q    <= ie_d;
         exl_q   <= exl_d;
         mask_q  <= mask_d;
         code_q  <= code_d;
         pend_q  <= pend_d;
         src_q   <= src_d;
`ifdef CP0_TIMER_EN
         count_q <= count_d;
         cmp_q   <= cmp_d;
`endif
      end
   end

   // MFC0 read mux, zero latency.
   always_comb begin
      dout = '0;
      case (sel)
         SEL_EPC:    dout = epc_q;
         SEL_STATUS: begin
            dout[ST_IE]  = ie_q;
            dout[ST_EXL] = exl_q;
         end
         SEL_MASK:   dout[NT-1:0] = mask_q;
         SEL_CAUSE:  begin
            dout[7:0]    = code_q;
            dout[8 +: NT] = pend_q;
         end
`ifdef CP0_TIMER_EN
         SEL_COUNT:   dout = count_q;
         SEL_COMPARE: dout = cmp_q;
`else
         SEL_COUNT:   dout = '0;
         SEL_COMPARE: dout = '0;
`endif
         default:    dout = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_intc.sv
// Scoreboard bench for cp0_intc: the driver pushes the expected per-cycle
// outputs from a behavioural model; a negedge monitor pops and compares.
module tb_cp0_intc;

   localparam int NS = 8;
`ifdef CP0_TIMER_EN
   localparam int NT = NS + 1;
`else
   localparam int NT = NS;
`endif
   localparam logic [31:0] ERET = 32'h0000_0018;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   inst;
   logic          cp0_en;
   logic [NS-1:0] irq_src;
   logic [31:0]   pc_in, din, dout, vec_pc, epc_out;
   logic          reg_write, is_eret, exc_take, in_handler;

   always #5 clk = ~clk;

   cp0_intc #(.NUM_SRC(NS), .DATA_W(32), .VEC_ADDR(32'h0000_0004)) dut (
      .clk(clk), .rst(rst), .inst(inst), .cp0_en(cp0_en), .irq_src(irq_src),
      .pc_in(pc_in), .din(din), .dout(dout), .reg_write(reg_write),
      .is_eret(is_eret), .exc_take(exc_take), .vec_pc(vec_pc),
      .epc_out(epc_out), .in_handler(in_handler)
   );

   typedef struct {
      bit        take;
      bit        inh;
      bit [31:0] dout;
      bit [31:0] epc;
      bit        rw;
      bit        er;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   // Behavioural model state
   bit [31:0]   m_epc, m_count, m_cmp, m_mask, m_pend;
   bit          m_ie, m_exl, m_inh;
   bit [7:0]    m_code;
   bit [NS-1:0] m_srcd;
   bit [NS-1:0] irq_v;

   function automatic bit [31:0] mt(input bit [2:0] s);
      return 32'h0080_0000 | (32'(s) << 11);
   endfunction

   function automatic bit [31:0] mf(input bit [2:0] s);
      return 32'(s) << 11;
   endfunction

   task automatic model_reset();
      m_epc = 0; m_count = 0; m_cmp = 0; m_mask = 0; m_pend = 0;
      m_ie = 0; m_exl = 0; m_inh = 0; m_code = 0; m_srcd = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input bit [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit [31:0] i, input bit en,
                      input bit [NS-1:0] irq, input bit [31:0] pc, input bit [31:0] d);
      exp_t e;
      bit [31:0] cand, np;
      int win;
      bit take, wr, er;
      bit [2:0] s;
      @(posedge clk); #1;
      rst = r; inst = i; cp0_en = en; irq_src = irq; pc_in = pc; din = d;
      s  = i[13:11];
      wr = en && i[23];
      er = en && (i[5:0] == 6'd24);
      cand = m_pend & m_mask;
      win = -1;
      for (int k = NT - 1; k >= 0; k--) if (cand[k]) win = k;
      take = !m_inh && m_ie && (win >= 0);
      e.take = take; e.inh = m_inh; e.epc = m_epc; e.er = er;
      e.rw = en && !i[23] && !er;
      case (s)
         3'd0: e.dout = m_epc;
         3'd1: e.dout = {30'd0, m_exl, m_ie};
         3'd2: e.dout = m_mask;
         3'd3: e.dout = (m_pend << 8) | 32'(m_code);
`ifdef CP0_TIMER_EN
         3'd4: e.dout = m_count;
         3'd5: e.dout = m_cmp;
`endif
         default: e.dout = 0;
      endcase
      q.push_back(e);
      if (r) model_reset();
      else begin
         np = m_pend;
`ifdef CP0_TIMER_EN
         if (wr && s == 5) np[NS] = 0;
`endif
         if (take) np[win] = 0;
         for (int k = 0; k < NS; k++) if (irq[k] && !m_srcd[k]) np[k] = 1;
`ifdef CP0_TIMER_EN
         if (m_count == m_cmp) np[NS] = 1;
         m_count = (wr && s == 4) ? d : m_count + 1;
         if (wr && s == 5) m_cmp = d;
`endif
         if (wr && s == 2) m_mask = d & ((32'd1 << NT) - 1);
         if (take) begin
            m_epc = pc; m_code = 8'(win + 1); m_exl = 1; m_inh = 1;
         end else begin
            if (wr && s == 0) m_epc = d;
            if (wr && s == 1) m_ie = d[0];
            if (m_inh && er) begin m_exl = 0; m_inh = 0; end
         end
         m_pend = np;
         m_srcd = irq;
      end
   endtask

   // Monitor: one expected record per cycle, compared away from the clock edge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("exc_take",   32'(exc_take),   32'(e.take));
         chk("in_handler", 32'(in_handler), 32'(e.inh));
         chk("dout",       dout,            e.dout);
         chk("epc_out",    epc_out,         e.epc);
         chk("reg_write",  32'(reg_write),  32'(e.rw));
         chk("is_eret",    32'(is_eret),    32'(e.er));
         chk("vec_pc",     vec_pc,          32'h0000_0004);
      end
   end

   initial begin
      rst = 1; inst = 0; cp0_en = 0; irq_src = 0; pc_in = 0; din = 0;
      repeat (2) @(posedge clk);
      model_reset();

      // reset state, enable all sources and IE
      cyc(0, mf(0), 1, 8'h00, 32'h0, 0);
      cyc(0, mf(1), 1, 8'h00, 32'h0, 0);
      cyc(0, mt(2), 1, 8'h00, 32'h0, 32'hFF);
      cyc(0, mt(1), 1, 8'h00, 32'h0, 32'h1);
      // single source 3 at pc 0x40
      cyc(0, mf(3), 1, 8'h08, 32'h40, 0);
      cyc(0, mf(3), 1, 8'h08, 32'h40, 0);
      cyc(0, mf(3), 1, 8'h00, 32'h44, 0);
      cyc(0, mf(1), 1, 8'h00, 32'h48, 0);
      cyc(0, ERET,  1, 8'h00, 32'h48, 0);
      cyc(0, mf(1), 1, 8'h00, 32'h4C, 0);
      // simultaneous sources 2 and 5
      cyc(0, mf(3), 1, 8'h24, 32'h50, 0);
      cyc(0, mf(3), 1, 8'h00, 32'h54, 0);
      cyc(0, mf(3), 1, 8'h00, 32'h58, 0);
      cyc(0, ERET,  1, 8'h00, 32'h5C, 0);
      cyc(0, mf(3), 1, 8'h00, 32'h60, 0);
      cyc(0, mf(3), 1, 8'h00, 32'h64, 0);
      cyc(0, ERET,  1, 8'h00, 32'h68, 0);
      // masked source 1 then unmask
      cyc(0, mt(2), 1, 8'h00, 32'h70, 32'hFD);
      cyc(0, mf(3), 1, 8'h02, 32'h70, 0);
      cyc(0, mf(3), 1, 8'h00, 32'h74, 0);
      cyc(0, mt(2), 1, 8'h00, 32'h78, 32'hFF);
      cyc(0, mf(3), 1, 8'h00, 32'h7C, 0);
      cyc(0, ERET,  1, 8'h00, 32'h7C, 0);
      // source 0 arrives during handler, no nesting
      cyc(0, mf(0), 1, 8'h10, 32'h90, 0);
      cyc(0, mf(0), 1, 8'h00, 32'h94, 0);
      cyc(0, mf(3), 1, 8'h01, 32'h98, 0);
      repeat (3) cyc(0, mf(3), 1, 8'h00, 32'h9C, 0);
      cyc(0, ERET,  1, 8'h00, 32'hA0, 0);
      cyc(0, mf(3), 1, 8'h00, 32'hA4, 0);
      cyc(0, ERET,  1, 8'h00, 32'hA8, 0);
      // MTC0 EPC coincident with a take
      cyc(0, mf(0), 1, 8'h40, 32'h7C, 0);
      cyc(0, mt(0), 1, 8'h00, 32'h80, 32'h100);
      cyc(0, mf(0), 1, 8'h00, 32'h84, 0);
      cyc(0, ERET,  1, 8'h00, 32'h88, 0);
      // reset in the middle of a handler with a pending source
      cyc(0, mf(0), 1, 8'h80, 32'hB0, 0);
      cyc(0, mf(0), 1, 8'h01, 32'hB4, 0);
      cyc(1, mf(3), 1, 8'h00, 32'hB8, 0);
      cyc(0, mf(3), 1, 8'h00, 32'hBC, 0);
      cyc(0, mf(1), 1, 8'h00, 32'hC0, 0);
`ifdef CP0_TIMER_EN
      // timer source at index NS
      cyc(0, mt(1), 1, 8'h00, 32'h0, 32'h1);
      cyc(0, mt(5), 1, 8'h00, 32'h0, 32'd10);
      cyc(0, mt(4), 1, 8'h00, 32'h0, 32'd0);
      cyc(0, mt(2), 1, 8'h00, 32'h0, 32'h1FF);
      for (int k = 0; k < 14; k++) cyc(0, mf(k % 2 == 0 ? 3'd3 : 3'd4), 1, 8'h00, 32'(k), 0);
      cyc(1, mf(3), 1, 8'h00, 32'h0, 0);
      cyc(0, mf(3), 1, 8'h00, 32'h0, 0);
      cyc(0, mf(4), 1, 8'h00, 32'h0, 0);
`endif

      // randomized traffic
      irq_v = 0;
      for (int n = 0; n < 2500; n++) begin
         int kind;
         bit [2:0] s;
         bit [31:0] d;
         irq_v = irq_v ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
         kind = $urandom_range(0, 9);
         s = 3'($urandom);
         d = $urandom;
         if (s == 3'd1 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         if ($urandom_range(0, 299) == 0)
            cyc(1, mf(s), 1, irq_v, $urandom, d);
         else if (kind < 2)
            cyc(0, mt(s), 1, irq_v, $urandom, d);
         else if (kind == 2)
            cyc(0, ERET, 1, irq_v, $urandom, d);
         else if (kind < 6)
            cyc(0, mf(s), 1, irq_v, $urandom, d);
         else
            cyc(0, $urandom, 0, irq_v, $urandom, d);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d queued expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
Parametrised coprocessor-0 exception/interrupt controller for the single-cycle MIPS core.
- Accepts NUM_SRC external exception/interrupt sources.
- Latches source rising edges into sticky pending bits, masks them, and selects one by fixed priority.
- Saves the return PC into EPC and redirects fetch to a vector; ERET returns from the handler.
- Implements MFC0/MTC0 access to EPC, Status, Mask and Cause; sits beside the register file and PC-select mux.

Parameters:
NUM_SRC, 8, number of exception sources (1..16); index 0 has highest priority
DATA_W, 32, data/PC width
VEC_ADDR, 32'h0000_0004, handler entry address driven on vec_pc

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
inst  in  32  current instruction; sel = inst[13:11], inst[23]=1 means MTC0, inst[5:0]=6'b011000 means ERET
cp0_en  in  1  current instruction is a COP0 op
irq_src  in  NUM_SRC  level exception/interrupt requests
pc_in  in  DATA_W  PC to save as return address
din  in  DATA_W  MTC0 write data (GPR rt)
dout  out  DATA_W  MFC0 read data
reg_write  out  1  GPR write enable for MFC0 (cp0_en & ~inst[23] & ~is_eret)
is_eret  out  1  cp0_en & ERET encoding
exc_take  out  1  redirect fetch to vec_pc this cycle
vec_pc  out  DATA_W  VEC_ADDR
epc_out  out  DATA_W  EPC, used as next PC on ERET
in_handler  out  1  state == HANDLER

Behaviour:
- Register map (sel):
  - 0 EPC (R/W)
  - 1 Status (R/W; bit0 IE, bit1 EXL read-only)
  - 2 Mask (R/W, low NUM_SRC bits)
  - 3 Cause (RO; [7:0] ExcCode, [8+NUM_SRC-1:8] pending)
  - 4 Count, 5 Compare (optional feature)
  - 6,7 read 0, writes ignored.
- Reset: EPC=0, Status=0 (IE=0, EXL=0), Mask=0, Cause=0, pending=0, src_d=0, state=IDLE. exc_take=0, in_handler=0, dout=EPC(0).
- Edge capture: src_d <= irq_src each cycle. pending[i] <= 1 when irq_src[i] & ~src_d[i]. A bit stays set until taken. A new edge in the same cycle as its clear leaves it set.
- Candidate = pending & Mask. winner = lowest set index. ExcCode = winner+1.
- FSM IDLE:
  - exc_take = IE & |candidate (combinational, same cycle).
  - On that posedge: EPC<=pc_in, Cause.ExcCode<=winner+1, pending[winner]<=0, EXL<=1, state<=HANDLER.
- FSM HANDLER:
  - exc_take=0; further sources stay pending, no nesting.
  - is_eret → EXL<=0, state<=IDLE.
  - A pending source re-enters no earlier than the cycle after ERET.
- ERET in IDLE: no state change; epc_out still valid.
- MTC0 (cp0_en & inst[23]): writes selected register at posedge. A simultaneous take wins over EPC/Status writes. Mask writes always apply.
- MFC0: dout = selected register combinationally, 0 latency.
- Reset mid-handler: immediate return to IDLE, all pending dropped.

Optional Feature:
CP0_TIMER_EN
- Defined:
  - Count (sel 4) increments every cycle and wraps at 2^DATA_W-1 → 0.
  - Compare (sel 5) is R/W.
  - Count==Compare sets internal timer pending bit at index NUM_SRC: lowest priority, masked by Mask[NUM_SRC], ExcCode NUM_SRC+1.
  - Writing Compare clears the timer pending bit; a match in the same cycle still sets it.
  - MTC0 to Count overrides the increment.
- Undefined: sel 4/5 read 0, writes ignored, no timer source.

Decomposition:
- Package cp0_pkg: sel constants (SEL_EPC..SEL_COMPARE), Status bit indices, ERET funct, FSM state enum {IDLE, HANDLER}.
- One sub-module prio_enc (parametrised NUM_SRC-wide priority encoder: valid + index).

Test Plan:
- Reset, then MTC0 Mask=8'hFF, Status=1; pulse irq_src[3] at pc_in=0x40 → exc_take=1 next cycle; EPC=0x40; Cause[7:0]=4; in_handler=1.
- Rising edges on src 2 and 5 in the same cycle → src 2 taken (code 3); after ERET, src 5 taken the following cycle (code 6).
- Mask[1]=0, edge on src 1 → no take, Cause[9]=1; MTC0 Mask[1]=1 → take next cycle, code 2.
- Edge on src 0 while in HANDLER → exc_take stays 0 until ERET; epc_out=saved PC on ERET cycle.
- MTC0 EPC=0x100 in the same cycle as a take at pc_in=0x80 → EPC=0x80.
- CP0_TIMER_EN: Compare=10, Mask[NUM_SRC]=1, IE=1 → take with code NUM_SRC+1 when Count reaches 10; rst mid-handler clears all, state IDLE.
